// File: rtl/loader_pkg.sv
// Shared types and constants for the boot-time program loader.
// Imported by the loader top level and its byte assembler.
package loader_pkg;

    typedef enum logic [1:0] {
        LEN,
        DATA,
        FIN,
        DONE
    } state_t;

    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned ADDR_STEP = 4;

endpackage

// File: rtl/byte_assembler.sv
// Packs a little-endian byte stream into 32-bit words.
// Shared by the length field and the data words of a load.
module byte_assembler
    import loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic [31:0] word,
    output logic        word_valid
);

    localparam logic [1:0] LAST = 2'(BYTES_PER_WORD - 1);

    logic [1:0]  cnt;
    logic [23:0] shreg;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt   <= '0;
            shreg <= '0;
        end else if (byte_valid) begin
            cnt   <= cnt + 2'd1;
            shreg <= {byte_in, shreg[23:8]};
        end
    end

    // Word is presented in the same cycle as its last byte so the
    // caller can register the write on the accepting edge.
    assign word       = {byte_in, shreg};
    assign word_valid = byte_valid && !clr && (cnt == LAST);

endmodule

// File: rtl/program_loader.sv
// Boot loader: UART byte stream -> 32-bit memory writes on the IO port.
// Hands memory back to the processor once the announced words are written.
module program_loader
    import loader_pkg::*;
#(
    parameter int               ADDRW     = 32,
    parameter int               DATAW     = 32,
    parameter logic [ADDRW-1:0] BASE_ADDR = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    input  logic             start,
    output logic             io_sel,
    output logic [ADDRW-1:0] addr_io,
    output logic [DATAW-1:0] data_io,
    output logic             we_io,
    output logic             done,
    output logic             loaded
);

    localparam logic [ADDRW-1:0] STEP = ADDRW'(ADDR_STEP);

    state_t      state;
    state_t      next_state;
    logic [31:0] n;
    logic [31:0] index;
    logic        take;
    logic        asm_clr;
    logic        asm_valid;
    logic [31:0] asm_word;

    assign take    = rx_valid && (state == LEN || state == DATA);
    assign asm_clr = (state == DONE) && start;

    byte_assembler u_asm (
        .clk        (clk),
        .rst        (rst),
        .clr        (asm_clr),
        .byte_in    (rx_data),
        .byte_valid (take),
        .word       (asm_word),
        .word_valid (asm_valid)
    );

    always_comb begin
        next_state = state;
        unique case (state)
            LEN: begin
                if (asm_valid)
                    next_state = (asm_word == '0) ? FIN : DATA;
            end
            DATA: begin
                // Leave once the strobe for word N-1 is on the bus.
                if (we_io && (index + 32'd1 == n))
                    next_state = FIN;
            end
            FIN: next_state = DONE;
            DONE: begin
                if (start)
                    next_state = LEN;
            end
            default: next_state = LEN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= LEN;
            n       <= '0;
            index   <= '0;
            io_sel  <= 1'b1;
            we_io   <= 1'b0;
            addr_io <= BASE_ADDR;
            data_io <= '0;
            done    <= 1'b0;
            loaded  <= 1'b0;
        end else begin
            state <= next_state;
            we_io <= (state == DATA) && asm_valid;
            if (state == DATA && asm_valid) begin
                data_io <= DATAW'(asm_word);
                addr_io <= BASE_ADDR + ADDRW'(index) * STEP;
            end
            if (state == LEN && asm_valid)
                n <= asm_word;
            if (asm_clr) begin
                n     <= '0;
                index <= '0;
            end else if (we_io) begin
                index <= index + 32'd1;
            end
            // Outputs follow the state being entered so they stay registered.
            done   <= (next_state == FIN);
            io_sel <= (next_state == LEN) || (next_state == DATA);
            loaded <= (next_state == DONE);
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: stimulus queues expected writes,
// a negedge monitor pops and compares whenever the loader writes or finishes.
module tb_program_loader;

    localparam logic [31:0] BASE = 32'h100;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        start;
    logic        io_sel;
    logic [31:0] addr_io;
    logic [31:0] data_io;
    logic        we_io;
    logic        done;
    logic        loaded;

    always #5 clk = ~clk;

    program_loader #(
        .ADDRW     (32),
        .DATAW     (32),
        .BASE_ADDR (BASE)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .start    (start),
        .io_sel   (io_sel),
        .addr_io  (addr_io),
        .data_io  (data_io),
        .we_io    (we_io),
        .done     (done),
        .loaded   (loaded)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          cyc;
    } wr_t;

    wr_t         exp_wr[$];
    int          exp_done[$];
    logic [31:0] words[$];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    logic        rst_edge;
    logic [31:0] last_a;
    logic [31:0] last_d;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_edge <= rst;
    end

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every write and every done pulse must match the scoreboard.
    always @(negedge clk) begin : mon
        wr_t e;
        int  d;
        if (rst_edge === 1'b1) begin
            last_a = BASE;
            last_d = '0;
        end else if (rst_edge === 1'b0) begin
            if (we_io) begin
                if (exp_wr.size() == 0) begin
                    chk("unexpected_write", 64'(addr_io), 64'hFFFF_FFFF_FFFF);
                end else begin
                    e = exp_wr.pop_front();
                    chk("wr_addr", 64'(addr_io), 64'(e.addr));
                    chk("wr_data", 64'(data_io), 64'(e.data));
                    chk("wr_cycle", 64'(cyc), 64'(e.cyc));
                    chk("wr_io_sel", 64'(io_sel), 64'd1);
                    last_a = e.addr;
                    last_d = e.data;
                end
            end else begin
                chk("hold_addr", 64'(addr_io), 64'(last_a));
                chk("hold_data", 64'(data_io), 64'(last_d));
            end
            if (done) begin
                if (exp_done.size() == 0) begin
                    chk("unexpected_done", 64'(cyc), 64'hFFFF_FFFF_FFFF);
                end else begin
                    d = exp_done.pop_front();
                    chk("done_cycle", 64'(cyc), 64'(d));
                    chk("done_io_sel", 64'(io_sel), 64'd0);
                    chk("done_loaded", 64'(loaded), 64'd0);
                end
            end
        end
    end

    task automatic drive_byte(input logic [7:0] b, input int gap,
                              input bit noise, output int c);
        repeat (gap) @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        start    = noise;
        c        = cyc;
    endtask

    task automatic end_byte();
        @(negedge clk);
        rx_valid = 1'b0;
        start    = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input int lo, input int hi,
                        input bit noisy, output int c);
        bit nz;
        nz = noisy && ($urandom_range(3, 0) == 0);
        drive_byte(b, $urandom_range(hi, lo), nz, c);
    endtask

    task automatic check_reset();
        chk("rst_io_sel", 64'(io_sel), 64'd1);
        chk("rst_we_io", 64'(we_io), 64'd0);
        chk("rst_addr", 64'(addr_io), 64'(BASE));
        chk("rst_data", 64'(data_io), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_loaded", 64'(loaded), 64'd0);
    endtask

    // Loads the contents of words[]; the model address is BASE + 4*i.
    task automatic do_load(input int lo, input int hi, input bit noisy);
        int          n;
        int          c;
        logic [31:0] w;
        logic [31:0] nl;
        n  = words.size();
        nl = 32'(n);
        for (int k = 0; k < 4; k++) begin
            send(nl[8*k +: 8], lo, hi, noisy, c);
            if (k == 3 && n == 0)
                exp_done.push_back(c + 1);
            end_byte();
        end
        for (int i = 0; i < n; i++) begin
            w = words[i];
            for (int k = 0; k < 4; k++) begin
                send(w[8*k +: 8], lo, hi, noisy, c);
                if (k == 3) begin
                    exp_wr.push_back('{BASE + 32'(i) * 32'd4, w, c + 1});
                    if (i == n - 1)
                        exp_done.push_back(c + 2);
                end
                end_byte();
            end
        end
    endtask

    task automatic wait_done();
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            #1;
            if (exp_wr.size() == 0 && exp_done.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            chk("load_timeout", 64'(exp_wr.size() + exp_done.size()), 64'd0);
            exp_wr.delete();
            exp_done.delete();
        end
        @(negedge clk);
        chk("after_loaded", 64'(loaded), 64'd1);
        chk("after_io_sel", 64'(io_sel), 64'd0);
        chk("after_done", 64'(done), 64'd0);
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_io_sel", 64'(io_sel), 64'd1);
        chk("start_loaded", 64'(loaded), 64'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int c;
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = '0;
        start    = 1'b0;
        repeat (3) @(negedge clk);
        check_reset();
        rst = 1'b0;

        words = '{32'h1234_5678, 32'hDEAD_BEEF};
        do_load(0, 0, 1'b0);
        wait_done();

        for (int k = 0; k < 6; k++) begin
            drive_byte(8'($urandom), $urandom_range(2, 0), 1'b0, c);
            end_byte();
        end
        repeat (2) @(negedge clk);
        chk("idle_loaded", 64'(loaded), 64'd1);
        chk("idle_io_sel", 64'(io_sel), 64'd0);

        do_start();
        words = '{32'($urandom)};
        do_load(0, 1, 1'b0);
        wait_done();

        do_start();
        words = '{32'($urandom), 32'($urandom), 32'($urandom)};
        do_load(7, 7, 1'b0);
        wait_done();

        do_start();
        words.delete();
        do_load(0, 2, 1'b0);
        wait_done();

        // Abort in the middle of word 1, then load from scratch.
        do_start();
        words = '{32'($urandom)};
        begin
            logic [31:0] w;
            logic [31:0] nl;
            nl = 32'd3;
            for (int k = 0; k < 4; k++) begin
                drive_byte(nl[8*k +: 8], 0, 1'b0, c);
                end_byte();
            end
            w = words[0];
            for (int k = 0; k < 4; k++) begin
                drive_byte(w[8*k +: 8], 0, 1'b0, c);
                if (k == 3)
                    exp_wr.push_back('{BASE, w, c + 1});
                end_byte();
            end
            for (int k = 0; k < 2; k++) begin
                drive_byte(8'($urandom), 0, 1'b0, c);
                end_byte();
            end
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_reset();
        rst = 1'b0;
        words = '{32'($urandom), 32'($urandom)};
        do_load(0, 2, 1'b0);
        wait_done();

        for (int it = 0; it < 8; it++) begin
            do_start();
            words.delete();
            for (int i = 0; i < int'($urandom_range(5, 0)); i++)
                words.push_back(32'($urandom));
            do_load(0, 3, 1'b1);
            wait_done();
        end

        repeat (3) @(negedge clk);
        chk("queues_empty", 64'(exp_wr.size() + exp_done.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
